// File: rtl/tape_controller_pkg.sv
// Shared definitions for the tape controller: command bit positions,
// FSM state encoding and the command-to-action decoder.
package tape_controller_pkg;

  localparam int CMD_W      = 8;
  localparam int CMD_PC_INC = 0;
  localparam int CMD_PC_DEC = 1;
  localparam int CMD_X_INC  = 2;
  localparam int CMD_X_DEC  = 3;
  localparam int CMD_A_INC  = 4;
  localparam int CMD_A_DEC  = 5;
  localparam int CMD_PUT    = 6;
  localparam int CMD_GET    = 7;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    WRBACK,
    RDREQ,
    RDCAP,
    PUT_W,
    GET_W
  } state_t;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_A_INC,
    ACT_A_DEC,
    ACT_X_INC,
    ACT_X_DEC,
    ACT_PUT,
    ACT_GET
  } action_t;

  // Pick the single action a command requests. A pair with both INC and DEC
  // set cancels itself and therefore does not block a lower-priority action.
  function automatic action_t decode_action(input logic [CMD_W-1:0] cmd);
    action_t act;
    act = ACT_NONE;
    if (cmd[CMD_GET])
      act = ACT_GET;
    else if (cmd[CMD_PUT])
      act = ACT_PUT;
    else if (cmd[CMD_X_INC] != cmd[CMD_X_DEC])
      act = cmd[CMD_X_INC] ? ACT_X_INC : ACT_X_DEC;
    else if (cmd[CMD_A_INC] != cmd[CMD_A_DEC])
      act = cmd[CMD_A_INC] ? ACT_A_INC : ACT_A_DEC;
    return act;
  endfunction

endpackage

// File: rtl/tape_controller_cache.sv
// tape_cell_cache: holds the cached cell A, head position X, the dirty bit
// and the clear counter, and drives the SRAM port for the clear sweep,
// write-back and read-refill sequences selected by the controller state.
module tape_cell_cache
  import tape_controller_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  state_t            state,
  input  action_t           action,
  input  logic              load_en,
  input  logic [DATA_W-1:0] load_data,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] a,
  output logic              dirty,
  output logic              clear_last,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re
);

  logic [ADDR_W-1:0] x;
  logic [ADDR_W-1:0] old_x;
  logic [ADDR_W-1:0] clr_cnt;

  assign clear_last = &clr_cnt;

  // Cache registers: A/X/dirty updates and the clear sweep counter.
  // NOTE: the external SRAM is never reset; its contents are zeroed by the
  // CLEAR sweep instead, so only these few control registers need a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a       <= '0;
      x       <= '0;
      old_x   <= '0;
      dirty   <= 1'b0;
      clr_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      case (state)
        CLEAR: clr_cnt <= clr_cnt + ADDR_W'(1);
        IDLE: begin
          case (action)
            ACT_A_INC: begin
              a     <= a + DATA_W'(1);
              dirty <= 1'b1;
            end
            ACT_A_DEC: begin
              a     <= a - DATA_W'(1);
              dirty <= 1'b1;
            end
            ACT_X_INC: begin
              old_x <= x;
              x     <= x + ADDR_W'(1);
            end
            ACT_X_DEC: begin
              old_x <= x;
              x     <= x - ADDR_W'(1);
            end
            default: ;
          endcase
        end
        WRBACK: dirty <= 1'b0;
        RDCAP:  a <= mem_rdata;
        GET_W: begin
          if (load_en) begin
            a     <= load_data;
            dirty <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // SRAM port: zero sweep in CLEAR, write-back of the old cell, refill read.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    mem_addr  = x;
    mem_wdata = a;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    case (state)
      CLEAR: begin
        mem_addr  = clr_cnt;
        mem_wdata = '0;
        mem_we    = ~rst;   // no write while reset is still asserted
      end
      WRBACK: begin
        mem_addr = old_x;
        mem_we   = 1'b1;
      end
      RDREQ: mem_re = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/tape_controller.sv
// tape_controller: control-unit FSM, program counter and the PUT/GET
// valid/ready handshakes; the tape cell cache lives in tape_cell_cache.
module tape_controller
  import tape_controller_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [CMD_W-1:0]  Command,
  output logic              IOReady,
  output logic              ZeroFlag,
  output logic [PC_W-1:0]   Prog_Addr,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_WData,
  output logic              Mem_We,
  output logic              Mem_Re,
  input  logic [DATA_W-1:0] Mem_RData,
  output logic [DATA_W-1:0] Out_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  input  logic [DATA_W-1:0] In_Data,
  input  logic              In_Valid,
  output logic              In_Ready
);

  state_t            state;
  state_t            state_next;
  action_t           action;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] a;
  logic              dirty;
  logic              clear_last;
  logic              load_en;

  // Command is only meaningful while idle.
  assign action    = (state == IDLE) ? decode_action(Command) : ACT_NONE;
  assign Prog_Addr = pc;
  assign Out_Data  = a;
  assign ZeroFlag  = (a == '0);

  // State register; reset restarts the clear sweep from any state.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= CLEAR;
    else       state <= state_next;
  end

  // Program counter moves with every command sampled in IDLE.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc <= '0;
    end else if (state == IDLE) begin
      if (Command[CMD_PC_INC] && !Command[CMD_PC_DEC])
        pc <= pc + PC_W'(1);
      else if (Command[CMD_PC_DEC] && !Command[CMD_PC_INC])
        pc <= pc - PC_W'(1);
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    IOReady    = 1'b0;
    Out_Valid  = 1'b0;
    In_Ready   = 1'b0;
    load_en    = 1'b0;
    case (state)
      CLEAR: if (clear_last) state_next = IDLE;
      IDLE: begin
        IOReady = 1'b1;
        case (action)
          ACT_X_INC, ACT_X_DEC: state_next = dirty ? WRBACK : RDREQ;
          ACT_PUT:              state_next = PUT_W;
          ACT_GET:              state_next = GET_W;
          default: ;
        endcase
      end
      WRBACK: state_next = RDREQ;
      RDREQ:  state_next = RDCAP;
      RDCAP:  state_next = IDLE;
      PUT_W: begin
        Out_Valid = 1'b1;
        if (Out_Ready) state_next = IDLE;
      end
      GET_W: begin
        In_Ready = 1'b1;
        if (In_Valid) begin
          load_en    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  tape_cell_cache #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_cache (
    .clk        (Clock),
    .rst        (Reset),
    .state      (state),
    .action     (action),
    .load_en    (load_en),
    .load_data  (In_Data),
    .mem_rdata  (Mem_RData),
    .a          (a),
    .dirty      (dirty),
    .clear_last (clear_last),
    .mem_addr   (Mem_Addr),
    .mem_wdata  (Mem_WData),
    .mem_we     (Mem_We),
    .mem_re     (Mem_Re)
  );

endmodule

// File: tb/tb_tape_controller.sv
// Self-checking bench for tape_controller: an SRAM model with an access log,
// and a tape-level reference model (cell array, head, cached value, PC).
module tb_tape_controller;

  localparam int NCELL = 256;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] Command = '0;
  logic       IOReady, ZeroFlag;
  logic [7:0] Prog_Addr;
  logic [7:0] Mem_Addr, Mem_WData, Mem_RData;
  logic       Mem_We, Mem_Re;
  logic [7:0] Out_Data;
  logic       Out_Valid;
  logic       Out_Ready = 1'b1;
  logic [7:0] In_Data = '0;
  logic       In_Valid = 1'b1;
  logic       In_Ready;

  tape_controller dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Command   (Command),
    .IOReady   (IOReady),
    .ZeroFlag  (ZeroFlag),
    .Prog_Addr (Prog_Addr),
    .Mem_Addr  (Mem_Addr),
    .Mem_WData (Mem_WData),
    .Mem_We    (Mem_We),
    .Mem_Re    (Mem_Re),
    .Mem_RData (Mem_RData),
    .Out_Data  (Out_Data),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .In_Data   (In_Data),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  // SRAM model with 1-cycle read latency and an access log.
  typedef struct {
    bit we;
    int addr;
    int data;
  } mem_ev_t;

  logic [7:0] sram [NCELL];
  logic [7:0] rdata = '0;
  mem_ev_t    mem_log[$];
  assign Mem_RData = rdata;

  always @(posedge Clock) begin
    if (Mem_We) begin
      sram[Mem_Addr] <= Mem_WData;
      mem_log.push_back('{1'b1, int'(Mem_Addr), int'(Mem_WData)});
    end
    if (Mem_Re) begin
      rdata <= sram[Mem_Addr];
      mem_log.push_back('{1'b0, int'(Mem_Addr), int'(sram[Mem_Addr])});
    end
  end

  // Reference model: tape contents, head, cached value, dirty, PC.
  int m_tape [NCELL];
  int m_a, m_x, m_pc;
  bit m_dirty;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Reset (asserted asynchronously mid-cycle), then check the clear sweep.
  task automatic reset_and_sweep(input string tag);
    bit low_ok;
    bit log_ok;
    #2 Reset = 1'b1;
    #1;
    mem_log.delete();
    n_checks++;
    if ({IOReady, ZeroFlag, Mem_We, Mem_Re, Out_Valid, In_Ready} !== 6'b010000) begin
      n_fail++;
      $display("FAIL %s reset_outputs: got {rdy,zf,we,re,ov,ir}=%b, want 010000", tag,
               {IOReady, ZeroFlag, Mem_We, Mem_Re, Out_Valid, In_Ready});
    end
    n_checks++;
    if (Prog_Addr !== 8'h00) begin
      n_fail++;
      $display("FAIL %s reset_pc: got %0h, want 0", tag, Prog_Addr);
    end
    tick();
    tick();
    n_checks++;
    if (Mem_We !== 1'b0 || mem_log.size() != 0) begin
      n_fail++;
      $display("FAIL %s we_during_reset: we=%b writes=%0d, want 0/0", tag, Mem_We, mem_log.size());
    end
    Reset = 1'b0;
    for (int i = 0; i < NCELL; i++) m_tape[i] = 0;
    m_a = 0; m_x = 0; m_pc = 0; m_dirty = 0;
    low_ok = 1'b1;
    for (int i = 0; i < NCELL; i++) begin
      if (IOReady !== 1'b0) low_ok = 1'b0;
      tick();
    end
    n_checks++;
    if (!low_ok) begin
      n_fail++;
      $display("FAIL %s clear_ioready_low: IOReady rose during the 256-cycle sweep", tag);
    end
    n_checks++;
    if (IOReady !== 1'b1 || ZeroFlag !== 1'b1) begin
      n_fail++;
      $display("FAIL %s after_clear: IOReady=%b ZeroFlag=%b, want 1/1", tag, IOReady, ZeroFlag);
    end
    log_ok = (mem_log.size() == NCELL);
    if (log_ok)
      for (int i = 0; i < NCELL; i++)
        if (!mem_log[i].we || mem_log[i].addr != i || mem_log[i].data != 0) log_ok = 1'b0;
    n_checks++;
    if (!log_ok) begin
      n_fail++;
      $display("FAIL %s clear_writes: got %0d accesses, want 256 zero writes to 0..255", tag,
               mem_log.size());
    end
  endtask

  // Issue one command with both handshakes ready; compare against the model.
  task automatic run_cmd(input logic [7:0] cmd, input string tag);
    mem_ev_t exp_q[$];
    int      exp_cycles;
    int      cycles;
    int      nx;
    bit      is_put;
    int      put_val;
    bit      log_ok;
    is_put    = 1'b0;
    put_val   = 0;
    Out_Ready = 1'b1;
    In_Valid  = 1'b1;
    if (cmd[0] && !cmd[1]) m_pc = (m_pc + 1) % 256;
    if (cmd[1] && !cmd[0]) m_pc = (m_pc + 255) % 256;
    if (cmd[7]) begin
      m_a = int'(In_Data); m_dirty = 1; exp_cycles = 2;
    end else if (cmd[6]) begin
      is_put = 1'b1; put_val = m_a; exp_cycles = 2;
    end else if (cmd[2] != cmd[3]) begin
      nx = cmd[2] ? (m_x + 1) % NCELL : (m_x + NCELL - 1) % NCELL;
      if (m_dirty) begin
        m_tape[m_x] = m_a;
        exp_q.push_back('{1'b1, m_x, m_a});
        exp_cycles = 4;
      end else begin
        exp_cycles = 3;
      end
      m_x = nx;
      exp_q.push_back('{1'b0, m_x, m_tape[m_x]});
      m_a = m_tape[m_x];
      m_dirty = 0;
    end else if (cmd[4] != cmd[5]) begin
      m_a = cmd[4] ? (m_a + 1) % 256 : (m_a + 255) % 256;
      m_dirty = 1;
      exp_cycles = 1;
    end else begin
      exp_cycles = 1;
    end

    mem_log.delete();
    Command = cmd;
    tick();
    Command = '0;
    if (is_put) begin
      n_checks++;
      if (Out_Valid !== 1'b1 || int'(Out_Data) != put_val) begin
        n_fail++;
        $display("FAIL %s put_data: valid=%b data=%0h, want 1/%0h", tag, Out_Valid, Out_Data, put_val);
      end
    end
    cycles = 1;
    while (IOReady !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
    n_checks++;
    if (cycles != exp_cycles) begin
      n_fail++;
      $display("FAIL %s latency cmd=%0h: got %0d cycles, want %0d", tag, cmd, cycles, exp_cycles);
    end
    log_ok = (mem_log.size() == exp_q.size());
    if (log_ok)
      foreach (exp_q[i])
        if (mem_log[i].we != exp_q[i].we || mem_log[i].addr != exp_q[i].addr ||
            mem_log[i].data != exp_q[i].data) log_ok = 1'b0;
    n_checks++;
    if (!log_ok) begin
      n_fail++;
      $display("FAIL %s mem_access cmd=%0h: got %0d accesses (first we=%0b addr=%0h data=%0h), want %0d",
               tag, cmd, mem_log.size(), (mem_log.size() > 0) ? mem_log[0].we : 1'b0,
               (mem_log.size() > 0) ? mem_log[0].addr : -1,
               (mem_log.size() > 0) ? mem_log[0].data : -1, exp_q.size());
    end
    n_checks++;
    if (ZeroFlag !== (m_a == 0) || int'(Prog_Addr) != m_pc) begin
      n_fail++;
      $display("FAIL %s flags cmd=%0h: zf=%b pc=%0h, want zf=%b pc=%0h", tag, cmd, ZeroFlag,
               Prog_Addr, (m_a == 0), m_pc);
    end
  endtask

  task automatic test_reset();
    reset_and_sweep("reset");
  endtask

  task automatic test_a_then_x();
    for (int i = 0; i < 3; i++) run_cmd(8'h10, "a_inc");
    run_cmd(8'h04, "x_inc_dirty");
    run_cmd(8'h08, "x_dec_clean");
    n_checks++;
    if (ZeroFlag !== 1'b0 || m_a != 3) begin
      n_fail++;
      $display("FAIL a_then_x zero_flag: got %b, want 0 (A=3)", ZeroFlag);
    end
    run_cmd(8'h40, "put_after_x");
  endtask

  task automatic test_a_dec_wrap();
    reset_and_sweep("wrap_reset");
    run_cmd(8'h20, "a_dec_wrap");
    run_cmd(8'h08, "x_dec_wrap");
    run_cmd(8'h40, "put_wrap");
  endtask

  task automatic test_put_stall();
    bit hold_ok;
    run_cmd(8'h10, "stall_prep");
    run_cmd(8'h10, "stall_prep");
    Out_Ready = 1'b0;
    Command = 8'h40;
    tick();
    Command = '0;
    hold_ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (Out_Valid !== 1'b1 || int'(Out_Data) != m_a || IOReady !== 1'b0) hold_ok = 1'b0;
      if (k == 4) Out_Ready = 1'b1;
      tick();
    end
    n_checks++;
    if (!hold_ok) begin
      n_fail++;
      $display("FAIL put_stall hold: valid/data not held for 5 cycles (data=%0h want %0h)", Out_Data, m_a);
    end
    n_checks++;
    if (IOReady !== 1'b1 || Out_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL put_stall release: IOReady=%b Out_Valid=%b, want 1/0", IOReady, Out_Valid);
    end
  endtask

  task automatic test_get();
    bit wait_ok;
    In_Valid = 1'b0;
    In_Data  = 8'h41;
    Command  = 8'h80;
    tick();
    Command = '0;
    wait_ok = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (In_Ready !== 1'b1 || IOReady !== 1'b0) wait_ok = 1'b0;
      tick();
    end
    if (In_Ready !== 1'b1) wait_ok = 1'b0;
    In_Valid = 1'b1;
    tick();
    In_Valid = 1'b0;
    m_a = 8'h41;
    m_dirty = 1;
    n_checks++;
    if (!wait_ok) begin
      n_fail++;
      $display("FAIL get_wait: In_Ready not held while In_Valid low");
    end
    n_checks++;
    if (IOReady !== 1'b1 || In_Ready !== 1'b0 || ZeroFlag !== 1'b0) begin
      n_fail++;
      $display("FAIL get_done: IOReady=%b In_Ready=%b zf=%b, want 1/0/0", IOReady, In_Ready, ZeroFlag);
    end
    run_cmd(8'h04, "get_wrback");
  endtask

  task automatic test_priority();
    int pc_before;
    pc_before = m_pc;
    run_cmd(8'h15, "prio_x_a_pc");
    n_checks++;
    if (int'(Prog_Addr) != (pc_before + 1) % 256) begin
      n_fail++;
      $display("FAIL prio_pc: got %0h, want %0h", Prog_Addr, (pc_before + 1) % 256);
    end
    run_cmd(8'h40, "prio_put");
  endtask

  task automatic test_random();
    logic [7:0] masks [4];
    logic [7:0] cmd;
    bit         tape_ok;
    masks = '{8'h3F, 8'h7F, 8'hFF, 8'h33};
    for (int i = 0; i < 200; i++) begin
      In_Data = 8'($urandom);
      cmd = 8'($urandom) & masks[$urandom_range(0, 3)];
      run_cmd(cmd, "random");
    end
    run_cmd(8'h40, "random_put");
    tape_ok = 1'b1;
    for (int i = 0; i < NCELL; i++)
      if (int'(sram[i]) != m_tape[i]) tape_ok = 1'b0;
    n_checks++;
    if (!tape_ok) begin
      n_fail++;
      $display("FAIL tape_contents: SRAM differs from the reference tape");
    end
  endtask

  task automatic test_reset_mid();
    Out_Ready = 1'b0;
    Command = 8'h41;
    tick();
    Command = '0;
    tick();
    reset_and_sweep("mid_reset");
    Out_Ready = 1'b1;
    run_cmd(8'h40, "after_mid_reset");
  endtask

  initial begin
    for (int i = 0; i < NCELL; i++) sram[i] = 8'($urandom);
    test_reset();
    test_a_then_x();
    test_a_dec_wrap();
    test_put_stall();
    test_get();
    test_priority();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tape_controller.md
TAPE_CONTROLLER -- requirements
Module: tape_controller

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, tape address width (2^ADDR_W cells).
REQ-002 SHALL have parameter DATA_W, default 8, cell width.
REQ-003 SHALL have parameter PC_W, default 8, program address width.
REQ-004 SHALL have port Clock, input, 1, sole clock; all state changes occur on its rising edge.
REQ-005 SHALL have port Reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port Command, input, 8, control-unit command bus: bit0 PC_INC, bit1 PC_DEC, bit2 X_INC, bit3 X_DEC, bit4 A_INC, bit5 A_DEC, bit6 PUT, bit7 GET.
REQ-007 SHALL have port IOReady, output, 1, high when the block is in IDLE and will accept Command.
REQ-008 SHALL have port ZeroFlag, output, 1, high when the cached cell value A equals 0.
REQ-009 SHALL have port Prog_Addr, output, PC_W, program counter.
REQ-010 SHALL have ports Mem_Addr (output, ADDR_W), Mem_WData (output, DATA_W), Mem_We (output, 1), Mem_Re (output, 1), and Mem_RData (input, DATA_W), forming an external synchronous SRAM with 1-cycle read latency.
REQ-011 SHALL have ports Out_Data (output, DATA_W), Out_Valid (output, 1) and Out_Ready (input, 1), forming the PUT valid/ready channel.
REQ-012 SHALL have ports In_Data (input, DATA_W), In_Valid (input, 1) and In_Ready (output, 1), forming the GET valid/ready channel.

Function
REQ-013 SHALL implement FSM states CLEAR, IDLE, WRBACK, RDREQ, RDCAP, PUT_W, GET_W.
REQ-014 SHALL sample Command only in IDLE; Command SHALL be ignored in all other states.
REQ-015 SHALL update PC independently of the FSM when Command is sampled: PC_INC -> +1, PC_DEC -> -1, both or neither -> hold, modulo 2^PC_W.
REQ-016 SHALL select one action among bits 2..7 by priority GET > PUT > X_INC/X_DEC > A_INC/A_DEC and drop the others; INC and DEC of the same pair both set SHALL be a no-op for that pair.
REQ-017 SHALL handle A_INC/A_DEC as follows: A is updated ±1 mod 2^DATA_W at the next edge, dirty is set, the FSM stays in IDLE, and IOReady stays high (zero-wait).
REQ-018 SHALL handle X_INC/X_DEC as follows: the new X is computed mod 2^ADDR_W; if dirty, go to WRBACK, else go to RDREQ.
REQ-019 In WRBACK, SHALL drive Mem_We=1, Mem_Addr=old X and Mem_WData=A for one cycle, clear dirty, then go to RDREQ.
REQ-020 In RDREQ, SHALL drive Mem_Re=1 and Mem_Addr=new X for one cycle, then go to RDCAP.
REQ-021 In RDCAP, SHALL load A from Mem_RData, then go to IDLE; an X move therefore takes 3 cycles when dirty and 2 when clean.
REQ-022 On PUT, SHALL enter PUT_W, hold Out_Valid=1 and Out_Data=A until a cycle with Out_Ready=1, then return to IDLE; if Out_Ready is already high, PUT completes in 1 cycle.
REQ-023 On GET, SHALL enter GET_W and hold In_Ready=1; in a cycle with In_Valid=1 it SHALL load A from In_Data, set dirty, and return to IDLE.
REQ-024 SHALL drive Mem_We, Mem_Re, Out_Valid and In_Ready low whenever they are not required by REQ-019..REQ-023.
REQ-025 SHALL derive ZeroFlag combinationally from A; it is valid whenever IOReady=1.
REQ-026 In CLEAR, SHALL write 0 to addresses 0..2^ADDR_W-1, one per cycle, with IOReady low, then enter IDLE; for ADDR_W=8 this takes 256 cycles.

Reset
REQ-027 On Reset, SHALL immediately set state=CLEAR, clear counter=0, X=0, A=0, dirty=0 and PC=0.
REQ-028 On Reset, outputs SHALL go to IOReady=0, ZeroFlag=1, Mem_We=0, Mem_Re=0, Out_Valid=0, In_Ready=0, Prog_Addr=0.
REQ-029 SHALL restart the full CLEAR sweep when Reset is asserted mid-operation, including mid-handshake; pending PUT/GET data SHALL be discarded.
REQ-030 SHALL drive Mem_We=1 only from the first rising edge after Reset deasserts.

Structure
REQ-031 SHALL place the Command bit indices (PC_INC..GET) and the FSM state encoding in the shared package used by the control unit.
REQ-032 SHALL contain one sub-module, tape_cell_cache, holding A, X, dirty and the write-back/read sequencing; the IO handshakes and PC SHALL remain in the top module.

Verification
REQ-033 SHALL verify reset release: IOReady=0 for 256 cycles with 256 writes of 0, then IOReady=1 and ZeroFlag=1.
REQ-034 SHALL verify A_INC ×3 then X_INC then X_DEC: a write of 3 to address 0, a read of address 1 (A=0), then a read of address 0 giving A=3 and ZeroFlag=0.
REQ-035 SHALL verify A_DEC with A=0: A=255 and dirty set; X_DEC at X=0: write-back to address 0, then a read of address 255.
REQ-036 SHALL verify PUT with Out_Ready held low for 4 cycles: Out_Valid high for 5 cycles, Out_Data stable, then return to IDLE.
REQ-037 SHALL verify GET with In_Data=0x41 and In_Valid delayed 2 cycles: A=0x41; a following X_INC performs a write-back of 0x41.
REQ-038 SHALL verify Command=X_INC|A_INC|PC_INC: only the X move executes, PC increments by 1, and A is unchanged.
